// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register:
// - operation-select encoding
// - burst FSM states
// - a helper that tells which operations may be used for a burst
package shreg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_SHL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_ROL   = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Only the shift and rotate operations are repeated by a burst.
    function automatic logic is_burst_mode(input mode_e m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) || (m == MODE_ROL);
    endfunction

endpackage

// File: rtl/usr_step_ctr.sv
// Loadable down-counter that tracks the remaining burst steps.
// Load wins over decrement. The counter never wraps below zero.
// The zero and one flags let the FSM detect the last step without a compare in the top.
module usr_step_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_zero,
    output logic             is_one
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a load replaces the count, otherwise decrement while above zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register with synchronous reset to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_zero = (cnt_q == '0);
    assign is_one  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register:
// - parallel load, shift and rotate in both directions, clear
// - serial in/out at both ends
// - counted burst-shift engine with busy/done status
// Optional build macro USR_PARITY_EN adds the q_par output, the even parity of q.
module universal_shift_register
    import shreg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             q_par
`endif
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    state_e           state_q;
    state_e           state_d;
    mode_e            burst_mode_q;
    mode_e            burst_mode_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    mode_e            cur_mode;
    mode_e            step_mode;
    logic             ctr_load;
    logic [CNT_W-1:0] ctr_load_val;
    logic             ctr_dec;
    logic             ctr_zero;
    logic             ctr_one;

    assign cur_mode = mode_e'(mode);

    usr_step_ctr #(
        .CNT_W(CNT_W)
    ) u_step_ctr (
        .clk     (clk),
        .rst     (rst),
        .load    (ctr_load),
        .load_val(ctr_load_val),
        .dec     (ctr_dec),
        .is_zero (ctr_zero),
        .is_one  (ctr_one)
    );

    // Burst FSM: chooses the operation for this edge and sequences busy/done
    always_comb begin
        state_d      = state_q;
        burst_mode_d = burst_mode_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        step_mode    = MODE_HOLD;
        ctr_load     = 1'b0;
        ctr_load_val = '0;
        ctr_dec      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A non-burst code runs a single empty RUN cycle, as if amt were zero
                    burst_mode_d = cur_mode;
                    ctr_load     = 1'b1;
                    ctr_load_val = is_burst_mode(cur_mode) ? amt : '0;
                    state_d      = ST_RUN;
                    busy_d       = 1'b1;
                end else if (en) begin
                    step_mode = cur_mode;
                end
            end
            ST_RUN: begin
                if (ctr_zero) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    step_mode = burst_mode_q;
                    ctr_dec   = 1'b1;
                    if (ctr_one) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Datapath: apply the selected operation to the register contents
    always_comb begin
        data_d = data_q;
        case (step_mode)
            MODE_LOAD:  data_d = d;
            MODE_SHR:   data_d = {sin_l, data_q[WIDTH-1:1]};
            MODE_SHL:   data_d = {data_q[WIDTH-2:0], sin_r};
            MODE_ROR:   data_d = {data_q[0], data_q[WIDTH-1:1]};
            MODE_ROL:   data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            MODE_CLEAR: data_d = RESET_VAL;
            default:    data_d = data_q;
        endcase
    end

    // State and data registers; reset aborts any burst without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q       <= RESET_VAL;
            state_q      <= ST_IDLE;
            burst_mode_q <= MODE_HOLD;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            data_q       <= data_d;
            state_q      <= state_d;
            burst_mode_q <= burst_mode_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign q      = data_q;
    assign sout_r = data_q[0];
    assign sout_l = data_q[WIDTH-1];
    assign busy   = busy_q;
    assign done   = done_q;

`ifdef USR_PARITY_EN
    assign q_par = ^data_q;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed testbench for universal_shift_register with WIDTH=8.
module tb_universal_shift_register;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHR   = 3'b010;
    localparam logic [2:0] M_SHL   = 3'b011;
    localparam logic [2:0] M_ROR   = 3'b100;
    localparam logic [2:0] M_ROL   = 3'b101;
    localparam logic [2:0] M_CLEAR = 3'b110;
    localparam logic [2:0] M_RSVD  = 3'b111;

    logic             clk;
    logic             rst;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic             start;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;
`ifdef USR_PARITY_EN
    logic             q_par;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;

    universal_shift_register #(
        .WIDTH(WIDTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .start (start),
        .amt   (amt),
        .q     (q),
        .sout_r(sout_r),
        .sout_l(sout_l),
        .busy  (busy),
        .done  (done)
`ifdef USR_PARITY_EN
        ,
        .q_par (q_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare q, busy and done against hand-computed values
    task automatic check_state(input string name, input logic [7:0] exp_q,
                               input logic exp_busy, input logic exp_done);
        check_cnt++;
        if (q !== exp_q || busy !== exp_busy || done !== exp_done) begin
            $display("[TB] FAIL %s: q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                     name, q, busy, done, exp_q, exp_busy, exp_done);
        end else begin
            pass_cnt++;
        end
`ifdef USR_PARITY_EN
        check_cnt++;
        if (q_par !== ^exp_q) begin
            $display("[TB] FAIL %s parity: q_par=%b expected %b", name, q_par, ^exp_q);
        end else begin
            pass_cnt++;
        end
`endif
    endtask

    task automatic single_op(input logic [2:0] m, input logic [7:0] dv);
        en   = 1'b1;
        mode = m;
        d    = dv;
        step();
        en   = 1'b0;
        mode = M_HOLD;
    endtask

    task automatic test_reset();
        single_op(M_LOAD, 8'hA5);
        check_state("reset_preload", 8'hA5, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_state("reset", 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_rotate();
        single_op(M_LOAD, 8'h81);
        check_state("load_81", 8'h81, 1'b0, 1'b0);
        single_op(M_ROL, 8'h00);
        check_state("rol", 8'h03, 1'b0, 1'b0);
        single_op(M_ROR, 8'h00);
        check_state("ror1", 8'h81, 1'b0, 1'b0);
        single_op(M_ROR, 8'h00);
        check_state("ror2", 8'hC0, 1'b0, 1'b0);
        check_cnt++;
        if (sout_l !== 1'b1 || sout_r !== 1'b0) begin
            $display("[TB] FAIL sout_c0: sout_l=%b sout_r=%b expected 1 0", sout_l, sout_r);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_shift();
        single_op(M_LOAD, 8'hF0);
        sin_l = 1'b0;
        single_op(M_SHR, 8'h00);
        check_state("shr1", 8'h78, 1'b0, 1'b0);
        single_op(M_SHR, 8'h00);
        single_op(M_SHR, 8'h00);
        check_state("shr3", 8'h1E, 1'b0, 1'b0);
        check_cnt++;
        if (sout_r !== 1'b0) begin
            $display("[TB] FAIL sout_r_1e: sout_r=%b expected 0", sout_r);
        end else begin
            pass_cnt++;
        end
        sin_r = 1'b1;
        single_op(M_SHL, 8'h00);
        check_state("shl_sin1", 8'h3D, 1'b0, 1'b0);
        sin_r = 1'b0;
    endtask

    task automatic test_hold_clear();
        en = 1'b0;
        mode = M_LOAD;
        d = 8'hFF;
        step();
        mode = M_HOLD;
        check_state("en_low_hold", 8'h3D, 1'b0, 1'b0);
        single_op(M_RSVD, 8'hFF);
        check_state("reserved_hold", 8'h3D, 1'b0, 1'b0);
        single_op(M_CLEAR, 8'hFF);
        check_state("clear", 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_burst();
        single_op(M_LOAD, 8'h01);
        sin_r = 1'b0;
        start = 1'b1;
        mode  = M_SHL;
        amt   = 4'd4;
        step();
        start = 1'b0;
        check_state("burst_start", 8'h01, 1'b1, 1'b0);
        en   = 1'b1;
        mode = M_LOAD;
        d    = 8'hFF;
        amt  = 4'd9;
        step();
        check_state("burst_s1", 8'h02, 1'b1, 1'b0);
        step();
        check_state("burst_s2", 8'h04, 1'b1, 1'b0);
        step();
        check_state("burst_s3", 8'h08, 1'b1, 1'b0);
        en   = 1'b0;
        mode = M_HOLD;
        step();
        check_state("burst_done", 8'h10, 1'b0, 1'b1);
        step();
        check_state("burst_after", 8'h10, 1'b0, 1'b0);
    endtask

    task automatic test_live_sin();
        start = 1'b1;
        mode  = M_SHR;
        amt   = 4'd2;
        step();
        start = 1'b0;
        sin_l = 1'b1;
        step();
        check_state("live_sin1", 8'h88, 1'b1, 1'b0);
        sin_l = 1'b0;
        step();
        check_state("live_sin0", 8'h44, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        mode  = M_SHL;
        amt   = 4'd0;
        step();
        check_state("amt0_start", 8'h44, 1'b1, 1'b0);
        start = 1'b0;
        step();
        check_state("amt0_done", 8'h44, 1'b0, 1'b1);
        start = 1'b1;
        mode  = M_LOAD;
        d     = 8'h55;
        amt   = 4'd3;
        step();
        start = 1'b0;
        check_state("loadburst_start", 8'h44, 1'b1, 1'b0);
        step();
        check_state("loadburst_done", 8'h44, 1'b0, 1'b1);
        step();
        check_state("loadburst_after", 8'h44, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        single_op(M_LOAD, 8'h96);
        start = 1'b1;
        mode  = M_ROR;
        amt   = 4'd8;
        step();
        start = 1'b0;
        mode  = M_HOLD;
        step();
        check_state("abort_s1", 8'h4B, 1'b1, 1'b0);
        step();
        check_state("abort_s2", 8'hA5, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_state("abort_rst", 8'h00, 1'b0, 1'b0);
        step();
        check_state("abort_after", 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        mode  = M_HOLD;
        d     = '0;
        sin_l = 1'b0;
        sin_r = 1'b0;
        start = 1'b0;
        amt   = '0;
        step();
        step();
        rst = 1'b0;
        test_reset();
        test_rotate();
        test_shift();
        test_hold_clear();
        test_burst();
        test_live_sin();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
